// File: rtl/tetris_pkg.sv
// Shared Tetris types and constants.
// Provides the move_t command encoding that is also used as the SPI opcode field.
// It also provides the default command header and the named opcode values.
package tetris_pkg;

    // Enumerators appear in SPI opcode order, so an accepted opcode casts directly to a move.
    typedef enum logic [2:0] {
        MOVE_NONE      = 3'd0,
        MOVE_LEFT      = 3'd1,
        MOVE_RIGHT     = 3'd2,
        MOVE_ROT_CW    = 3'd3,
        MOVE_ROT_CCW   = 3'd4,
        MOVE_SOFT_DROP = 3'd5,
        MOVE_HARD_DROP = 3'd6
    } move_t;

    localparam logic [3:0] CMD_HEADER_DEFAULT = 4'hA;

    localparam logic [2:0] OP_NONE      = 3'd0;
    localparam logic [2:0] OP_LEFT      = 3'd1;
    localparam logic [2:0] OP_RIGHT     = 3'd2;
    localparam logic [2:0] OP_ROT_CW    = 3'd3;
    localparam logic [2:0] OP_ROT_CCW   = 3'd4;
    localparam logic [2:0] OP_SOFT_DROP = 3'd5;
    localparam logic [2:0] OP_HARD_DROP = 3'd6;
    localparam logic [2:0] OP_RESERVED  = 3'd7;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
// Ports:
//   clk, reset    : clock and asynchronous active-high reset. Reset clears the pointers and the count.
//   push, din     : write request and data. A write to a full FIFO is ignored unless a pop
//                   also succeeds in the same cycle.
//   pop           : read request. A pop on an empty FIFO is ignored.
//   dout          : head entry. It is only meaningful when empty is low.
//   count         : current occupancy, 0..DEPTH.
//   full, empty   : occupancy flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW-1:0] PtrOne   = 1;
    localparam logic [PtrW:0]   CntOne   = 1;
    localparam logic [PtrW:0]   CntDepth = DEPTH;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntDepth);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop that succeeds frees a slot in the same cycle, so a push into a full FIFO is still taken.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntOne;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset. Entries outside the occupied window are don't-care.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/spi_move_queue.sv
// Command decoder and per-tick move queue between the SPI receiver and game_executioner.
// Ports:
//   clk, reset : system clock and asynchronous active-high reset.
//   byte_valid : one-cycle strobe marking that byte_data holds a complete SPI byte.
//   byte_data  : the received SPI byte, laid out as {header[3:0], ignored, opcode[2:0]}.
//   game_tick  : one-cycle strobe at each game step. Each tick releases at most one move.
//   move       : the current move. It holds its value until the next game_tick.
//   move_valid : one-cycle pulse when move was freshly popped from the queue.
//   count      : queue occupancy.
//   overflow   : sticky. Set when a valid move was dropped because the queue was full.
//   bad_cmd    : sticky. Set when a byte had a wrong header or the reserved opcode.
module spi_move_queue
    import tetris_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter logic [3:0]  CMD_HEADER = CMD_HEADER_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    input  logic                     game_tick,
    output move_t                    move,
    output logic                     move_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     bad_cmd
);

    logic       header_ok;
    logic [2:0] opcode;
    logic       is_move;
    logic       is_bad;
    logic       push_req;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] fifo_dout;

    move_t move_q, move_d;
    logic  move_valid_q, move_valid_d;
    logic  overflow_q, overflow_d;
    logic  bad_cmd_q, bad_cmd_d;

    // Bit 3 of the byte is intentionally ignored.
    assign header_ok = (byte_data[7:4] == CMD_HEADER);
    assign opcode    = byte_data[2:0];
    // Opcode 0 with a good header is a keep-alive: it is neither queued nor flagged.
    assign is_move   = header_ok && (opcode != OP_NONE) && (opcode != OP_RESERVED);
    assign is_bad    = !header_ok || (opcode == OP_RESERVED);
    assign push_req  = byte_valid && is_move;

    sync_fifo #(
        .WIDTH (3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (game_tick),
        .din   (opcode),
        .dout  (fifo_dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        move_d       = move_q;
        move_valid_d = 1'b0;
        overflow_d   = overflow_q;
        bad_cmd_d    = bad_cmd_q;

        // The pop sees the occupancy from before this cycle's push, so an entry pushed
        // into an empty queue is never bypassed to the output.
        if (game_tick) begin
            if (fifo_empty) begin
                move_d = MOVE_NONE;
            end else begin
                move_d       = move_t'(fifo_dout);
                move_valid_d = 1'b1;
            end
        end

        // A full queue is never empty, so a coincident tick always frees a slot.
        if (push_req && fifo_full && !game_tick) begin
            overflow_d = 1'b1;
        end

        if (byte_valid && is_bad) begin
            bad_cmd_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            move_q       <= MOVE_NONE;
            move_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            bad_cmd_q    <= 1'b0;
        end else begin
            move_q       <= move_d;
            move_valid_q <= move_valid_d;
            overflow_q   <= overflow_d;
            bad_cmd_q    <= bad_cmd_d;
        end
    end

    assign move       = move_q;
    assign move_valid = move_valid_q;
    assign overflow   = overflow_q;
    assign bad_cmd    = bad_cmd_q;

endmodule

// File: doc/spi_move_queue.md
Name: spi_move_queue

Overview:
- Sits between the SPI receiver and game_executioner.
- Validates and decodes command bytes from the MCU into tetris_pkg::move_t, then buffers them in a small FIFO.
- Releases exactly one move per game tick, so player inputs arriving between ticks are queued rather than lost.
- Single clock domain (HSOSC_clk). The SPI byte strobe is already synchronized before it reaches this block.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CMD_HEADER, 4'hA, required value of byte_data[7:4] for a byte to be a valid command.

Ports:
- clk  in  1  system clock (HSOSC_clk)
- reset  in  1  asynchronous, active-high reset
- byte_valid  in  1  one-cycle strobe: byte_data holds a complete SPI byte
- byte_data  in  8  received SPI byte
- game_tick  in  1  one-cycle strobe, game step boundary
- move  out  3  tetris_pkg::move_t, current move for game_executioner
- move_valid  out  1  one-cycle pulse: move was freshly popped this tick
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a valid command was dropped because the FIFO was full
- bad_cmd  out  1  sticky: a byte with a wrong header or reserved opcode was rejected

Behaviour:
- Reset (async assert, sync release) sets: move=MOVE_NONE, move_valid=0, count=0, overflow=0, bad_cmd=0. FIFO pointers are cleared; FIFO contents are don't-care.
- Decode, combinational on byte_data:
  - Header check: byte_data[7:4]==CMD_HEADER, otherwise reject.
  - Opcode byte_data[2:0]: 0 NONE, 1 LEFT, 2 RIGHT, 3 ROT_CW, 4 ROT_CCW, 5 SOFT_DROP, 6 HARD_DROP, 7 reserved (reject).
  - byte_data[3] is ignored.
  - Opcode 0 with a valid header is accepted but never enqueued (keep-alive).
- Push: byte_valid && decoded opcode in 1..6.
  - Entry is written at the clock edge; count increments at N+1.
  - FIFO full and no pop in the same cycle: drop the byte, set overflow. FIFO contents are unchanged.
- Reject: byte_valid && (wrong header || opcode 7). Set bad_cmd; nothing is enqueued.
- Pop: game_tick && count!=0.
  - At M+1: move=head entry, move_valid=1, count decrements.
  - game_tick with count==0: at M+1, move=MOVE_NONE, move_valid=0.
  - move holds its value until the next game_tick.
  - move_valid is high for exactly one cycle after each pop.
- Simultaneous push and pop in one cycle:
  - Both occur; count is unchanged.
  - When full, the push is accepted because a slot frees in the same cycle.
  - When empty: no bypass. The pop sees empty, so move=MOVE_NONE; the pushed entry lands and count=1.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
- HARD_DROP is queued like any other move; no queue flush.
- Sticky flags clear only on reset.
- Reset mid-operation clears the queue immediately (asynchronous). Strobes coincident with reset release are ignored.
- byte_valid wider than one cycle is a protocol error: each high cycle counts as a push. The bench must not drive it that way except in an explicit error test.

Decomposition:
- tetris_pkg receives:
  - move_t enum (3 bits, values in opcode order above)
  - CMD_HEADER_DEFAULT constant
  - opcode localparams
- Sub-module sync_fifo #(WIDTH, DEPTH): single-clock FIFO with push, pop, dout (head, show-ahead), count, full, empty. It is reusable for the planned SPI frame path.
- spi_move_queue holds the decode, push/pop gating, output register and sticky flags.

Test Plan:
- Reset: assert reset mid-stream with count=3 -> count=0, move=NONE, flags=0 asynchronously, before the next clk edge.
- Ordered drain: push 0xA1, 0xA2, 0xA3, then three game_ticks -> move = LEFT, RIGHT, ROT_CW on successive ticks, each with a one-cycle move_valid; a fourth tick gives move=NONE, move_valid=0.
- Overflow: push 0xA1..0xA5 with DEPTH=4 -> count=4, overflow=1; draining yields LEFT, RIGHT, ROT_CW, ROT_CCW (SOFT_DROP lost).
- Full with simultaneous push and pop: DEPTH full, byte_valid=0xA6 in the same cycle as game_tick -> count stays 4, overflow=0, HARD_DROP is last out after 4 more ticks.
- Rejection: bytes 0x51, 0xA7, 0xA0 -> bad_cmd=1 after the first two, count=0 throughout, 0xA0 sets nothing.
- Empty with simultaneous push and pop: byte_valid=0xA5 and game_tick in the same cycle on an empty queue -> move=NONE, count=1; next tick -> move=SOFT_DROP, move_valid pulse.
